// File: rtl/pattern_tx.sv
// pattern_tx: loads a W-bit pattern and shifts it out MSB-first, repeating rep+1 times with GAP idle cycles between frames.
// Optional feature macro PATTERN_TX_PARITY_EN appends an even-parity bit (PAR state) to every frame.
module pattern_tx #(
  parameter int W   = 4,
  parameter int GAP = 1
) (
  input  logic         ck,
  input  logic         rs,
  input  logic         start,
  input  logic [W-1:0] pat,
  input  logic [3:0]   rep,
  output logic         out,
  output logic         busy,
  output logic         done,
  output logic [2:0]   c
);

  localparam int            CW      = $clog2(W) + 1;
  localparam logic [CW-1:0] LastBit = CW'(W);
  localparam logic [3:0]    GapLast = 4'(GAP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_SHIFT = 3'b001,
    S_GAP   = 3'b010,
    S_DONE  = 3'b011,
    S_PAR   = 3'b100
  } state_e;

  state_e        state_q, state_d;
  logic          out_q, out_d;
  logic [W-1:0]  pat_q, pat_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic [3:0]    rep_q, rep_d;
  logic [3:0]    gapcnt_q, gapcnt_d;
  logic          frameEnd;

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      state_q  <= S_IDLE;
      out_q    <= 1'b0;
      pat_q    <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      rep_q    <= '0;
      gapcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      pat_q    <= pat_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      rep_q    <= rep_d;
      gapcnt_q <= gapcnt_d;
    end
  end

  // out_d is the value presented during the next cycle; shift_q holds the bits not yet sent.
  always_comb begin
    state_d  = state_q;
    out_d    = 1'b0;
    pat_d    = pat_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    rep_d    = rep_q;
    gapcnt_d = gapcnt_q;
    frameEnd = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d    = pat;
          shift_d  = {pat[W-2:0], 1'b0};
          out_d    = pat[W-1];
          bitcnt_d = CW'(1);
          rep_d    = rep;
          gapcnt_d = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bitcnt_q == LastBit) begin
`ifdef PATTERN_TX_PARITY_EN
          state_d = S_PAR;
          out_d   = ^pat_q;
`else
          frameEnd = 1'b1;
`endif
        end else begin
          out_d    = shift_q[W-1];
          shift_d  = {shift_q[W-2:0], 1'b0};
          bitcnt_d = bitcnt_q + CW'(1);
        end
      end
`ifdef PATTERN_TX_PARITY_EN
      S_PAR: begin
        frameEnd = 1'b1;
      end
`endif
      S_GAP: begin
        if (gapcnt_q == GapLast) begin
          state_d  = S_SHIFT;
          out_d    = pat_q[W-1];
          shift_d  = {pat_q[W-2:0], 1'b0};
          bitcnt_d = CW'(1);
          rep_d    = rep_q - 4'd1;
        end else begin
          gapcnt_d = gapcnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared exit after the last bit of a frame (data bit, or parity bit when enabled).
    if (frameEnd) begin
      if (rep_q != 4'd0) begin
        if (GAP == 0) begin
          state_d  = S_SHIFT;
          out_d    = pat_q[W-1];
          shift_d  = {pat_q[W-2:0], 1'b0};
          bitcnt_d = CW'(1);
          rep_d    = rep_q - 4'd1;
        end else begin
          state_d  = S_GAP;
          gapcnt_d = 4'd1;
        end
      end else begin
        state_d = S_DONE;
      end
    end
  end

  assign out  = out_q;
  assign c    = state_q;
  assign done = (state_q == S_DONE);
`ifdef PATTERN_TX_PARITY_EN
  assign busy = (state_q == S_SHIFT) || (state_q == S_GAP) || (state_q == S_PAR);
`else
  assign busy = (state_q == S_SHIFT) || (state_q == S_GAP);
`endif

endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: directed checks of pattern_tx with GAP=1 and GAP=0 instances and a behavioural 1011 loopback detector.
// Expected streams follow the PATTERN_TX_PARITY_EN setting used for the build.
module tb_pattern_tx;

`ifdef PATTERN_TX_PARITY_EN
  localparam logic [31:0] FrameBits   = 32'b10111;
  localparam int          FrameLen    = 5;
  localparam logic [31:0] RepBits     = 32'b10111_0_10111_0_10111;
  localparam int          RepLen      = 17;
  localparam logic [31:0] B2bBits     = 32'b11011_11011;
  localparam int          B2bLen      = 10;
  localparam int          B2bDet      = 2;
`else
  localparam logic [31:0] FrameBits   = 32'b1011;
  localparam int          FrameLen    = 4;
  localparam logic [31:0] RepBits     = 32'b1011_0_1011_0_1011;
  localparam int          RepLen      = 14;
  localparam logic [31:0] B2bBits     = 32'b1101_1101;
  localparam int          B2bLen      = 8;
  localparam int          B2bDet      = 1;
`endif

  logic       ck = 1'b0;
  logic       rs = 1'b1;
  logic       start1 = 1'b0, start0 = 1'b0;
  logic [3:0] pat1 = '0, pat0 = '0, rep1 = '0, rep0 = '0;
  logic       out1, busy1, done1, out0, busy0, done0;
  logic [2:0] c1, c0;
  logic       useZero = 1'b0;
  logic       mOut, mBusy, mDone;
  logic [2:0] mC;
  logic [2:0] hist = '0;
  int         checks = 0;
  int         errors = 0;
  int         detCount = 0;
  int         detBefore;

  always #5 ck = ~ck;

  pattern_tx #(.W(4), .GAP(1)) dut (
    .ck(ck), .rs(rs), .start(start1), .pat(pat1), .rep(rep1),
    .out(out1), .busy(busy1), .done(done1), .c(c1)
  );

  pattern_tx #(.W(4), .GAP(0)) dut0 (
    .ck(ck), .rs(rs), .start(start0), .pat(pat0), .rep(rep0),
    .out(out0), .busy(busy0), .done(done0), .c(c0)
  );

  assign mOut  = useZero ? out0  : out1;
  assign mBusy = useZero ? busy0 : busy1;
  assign mDone = useZero ? done0 : done1;
  assign mC    = useZero ? c0    : c1;

  // overlapping 1011 detector fed by the selected transmitter, asserting on the edge after the last bit
  always @(posedge ck or posedge rs) begin
    if (rs) begin
      hist <= '0;
    end else begin
      hist <= {hist[1:0], mOut};
      if ({hist, mOut} == 4'b1011) detCount <= detCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // start pulse for one edge on the selected instance; pat/rep are then scrambled to prove latching
  task automatic applyStimulus(input logic [3:0] p, input logic [3:0] r);
    @(negedge ck);
    if (useZero) begin pat0 = p; rep0 = r; start0 = 1'b1; end
    else begin pat1 = p; rep1 = r; start1 = 1'b1; end
    @(negedge ck);
    start0 = 1'b0; start1 = 1'b0;
    pat0 = ~p; pat1 = ~p; rep0 = 4'd0; rep1 = 4'd0;
  endtask

  task automatic checkStream(input string tag, input logic [31:0] bits, input int n, input bit poke);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_out"}, 32'(mOut), 32'(bits[n-1-i]));
      checkOutput({tag, "_busy"}, 32'(mBusy), 32'd1);
      checkOutput({tag, "_nodone"}, 32'(mDone), 32'd0);
      if (poke) begin
        if (useZero) start0 = (i % 3 == 1);
        else start1 = (i % 3 == 1);
      end
      @(negedge ck);
    end
    start0 = 1'b0; start1 = 1'b0;
    checkOutput({tag, "_done"}, 32'(mDone), 32'd1);
    checkOutput({tag, "_donebusy"}, 32'(mBusy), 32'd0);
    checkOutput({tag, "_donec"}, 32'(mC), 32'd3);
    checkOutput({tag, "_doneout"}, 32'(mOut), 32'd0);
    @(negedge ck);
    checkOutput({tag, "_idledone"}, 32'(mDone), 32'd0);
    checkOutput({tag, "_idlec"}, 32'(mC), 32'd0);
  endtask

  initial begin
    rs = 1'b1;
    #50;
    checkOutput("rst_out", 32'(out1), 32'd0);
    checkOutput("rst_busy", 32'(busy1), 32'd0);
    checkOutput("rst_done", 32'(done1), 32'd0);
    checkOutput("rst_c", 32'(c1), 32'd0);
    checkOutput("rst_c0", 32'(c0), 32'd0);
    checkOutput("rst_out0", 32'(out0), 32'd0);
    #50;
    rs = 1'b0;

    $display("[TB] single frame 1011");
    useZero = 1'b0;
    detBefore = detCount;
    applyStimulus(4'b1011, 4'd0);
    checkStream("single", FrameBits, FrameLen, 1'b0);
    checkOutput("single_det", 32'(detCount - detBefore), 32'd1);

    $display("[TB] repeats with gap");
    detBefore = detCount;
    applyStimulus(4'b1011, 4'd2);
    checkStream("repgap", RepBits, RepLen, 1'b0);
    checkOutput("repgap_det", 32'(detCount - detBefore), 32'd3);

    $display("[TB] back-to-back with ignored start");
    useZero = 1'b1;
    detBefore = detCount;
    applyStimulus(4'b1101, 4'd1);
    checkStream("b2b", B2bBits, B2bLen, 1'b1);
    checkOutput("b2b_det", 32'(detCount - detBefore), 32'(B2bDet));
    checkOutput("b2b_c1idle", 32'(c1), 32'd0);

    $display("[TB] reset mid-frame");
    useZero = 1'b0;
    applyStimulus(4'b1011, 4'd0);
    checkOutput("mid_bit0", 32'(mOut), 32'd1);
    @(negedge ck);
    checkOutput("mid_bit1", 32'(mOut), 32'd0);
    #2 rs = 1'b1;
    #1;
    checkOutput("mid_rst_out", 32'(mOut), 32'd0);
    checkOutput("mid_rst_c", 32'(mC), 32'd0);
    checkOutput("mid_rst_busy", 32'(mBusy), 32'd0);
    @(negedge ck);
    rs = 1'b0;
    detBefore = detCount;
    for (int i = 0; i < 4; i++) begin
      checkOutput("mid_nodone", 32'(mDone), 32'd0);
      checkOutput("mid_idle", 32'(mC), 32'd0);
      @(negedge ck);
    end
    applyStimulus(4'b1011, 4'd0);
    checkStream("after", FrameBits, FrameLen, 1'b0);
    checkOutput("after_det", 32'(detCount - detBefore), 32'd1);

`ifdef PATTERN_TX_PARITY_EN
    $display("[TB] parity frame");
    applyStimulus(4'b1001, 4'd0);
    checkStream("par", 32'b10010, 5, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

endmodule
